// File: rtl/alu_share_arbiter.sv
// One shared 32-bit ALU serving two requesters with round-robin or fixed-priority arbitration.
// Each operation takes three cycles: accept, execute, respond. Each port also has a saturating count of completed operations.

module alu_share_alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        aluc,
    output logic [DATA_W-1:0] r
);
    localparam int SH_W = $clog2(DATA_W);

    logic signed [DATA_W-1:0] b_s;
    logic        [SH_W-1:0]   shamt;

    assign b_s   = b;
    assign shamt = a[SH_W-1:0];

    // Bit 3 only matters for the shift group, so sra can reuse code 0111 with bit 3 set.
    always_comb begin
        r = '0;
        casez (aluc)
            4'b?000: r = a + b;
            4'b?100: r = a - b;
            4'b?001: r = a & b;
            4'b?101: r = a | b;
            4'b?010: r = a ^ b;
            4'b?110: r = b << (DATA_W / 2);
            4'b0011: r = b << shamt;
            4'b0111: r = b >> shamt;
            4'b1111: r = $unsigned(b_s >>> shamt);
            default: r = '0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int CNT_W       = 16,
    parameter bit P0_PRIORITY = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_aluc,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_r,
    output logic             rsp0_zero,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_aluc,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_r,
    output logic             rsp1_zero,
    input  logic             rsp1_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              owner_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [3:0]        aluc_p0;
    logic [DATA_W-1:0] alu_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // On a tie, port 0 wins unless it was the last port granted, or always when fixed priority is set.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || P0_PRIORITY || last_grant);
        grant1 = req1_valid && !grant0;
    end

    assign req0_ready = (state == IDLE) && !reset && grant0;
    assign req1_ready = (state == IDLE) && !reset && grant1;

    alu_share_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (a_p0),
        .b    (b_p0),
        .aluc (aluc_p0),
        .r    (alu_r)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner_p0   <= 1'b0;
            a_p0       <= '0;
            b_p0       <= '0;
            aluc_p0    <= '0;
            busy       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_r     <= '0;
            rsp1_r     <= '0;
            rsp0_zero  <= 1'b0;
            rsp1_zero  <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            case (state)
                // stage p0: latch winner's operands
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_p0       <= grant1 ? req1_a    : req0_a;
                        b_p0       <= grant1 ? req1_b    : req0_b;
                        aluc_p0    <= grant1 ? req1_aluc : req0_aluc;
                        owner_p0   <= grant1;
                        last_grant <= grant1;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                // stage p1: capture ALU result into the owner's response register
                EXEC: begin
                    if (owner_p0) begin
                        rsp1_r     <= alu_r;
                        rsp1_zero  <= (alu_r == '0);
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_r     <= alu_r;
                        rsp0_zero  <= (alu_r == '0);
                        rsp0_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                // stage p2: hold the response until the owner takes it
                RESP: begin
                    if (owner_p0 && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        cnt1       <= sat_inc(cnt1);
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (!owner_p0 && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        cnt0       <= sat_inc(cnt0);
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit a/b, 4-bit aluc, 32-bit r) between two requesters: the pipeline EX stage (port 0) and the I/O/debug engine (port 1).
- Round-robin arbitration, registered operands and result, and a valid/ready handshake per port.
- Instantiates the ALU internally and is the only driver of its inputs.
- Also keeps a saturating completed-operation counter per port for debug readout.

Parameters:
- CNT_W, 16, width of per-port completed-operation counters.
- P0_PRIORITY, 0, 1 = port 0 always wins a tie (fixed priority); 0 = round-robin.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req0_valid  in  1  port 0 request
- req0_a  in  32  port 0 operand a
- req0_b  in  32  port 0 operand b
- req0_aluc  in  4  port 0 ALU function code
- req0_ready  out  1  port 0 request accepted this cycle
- rsp0_valid  out  1  port 0 result available
- rsp0_r  out  32  port 0 result
- rsp0_zero  out  1  port 0 result == 0
- rsp0_ready  in  1  port 0 consumer accepts result
- req1_* / rsp1_*  same as port 0, for port 1
- busy  out  1  FSM not in IDLE
- cnt0, cnt1  out  CNT_W  completed ops per port

Behaviour:
- FSM states:
  - IDLE: if any reqN_valid, pick a winner, latch its a/b/aluc and owner id, assert reqN_ready for that port only (combinational, same cycle), go to EXEC.
  - EXEC: one cycle; ALU driven from latched operands; r captured into the result register; zero = (r == 0); go to RESP.
  - RESP: rspN_valid=1 for the owner only, rspN_r/rspN_zero held stable. On rspN_ready: increment cntN, go to IDLE.
- Latency: request accepted at cycle T → rsp_valid at T+2. Minimum initiation interval is 3 cycles (back-to-back with immediate ready).
- Arbitration:
  - Round-robin pointer last_grant, reset 1, so port 0 wins the first tie.
  - On a tie, grant the port != last_grant. A single requester is always granted.
  - last_grant updates only on grant.
  - If P0_PRIORITY=1, port 0 wins every tie.
- Handshake rules:
  - reqN_ready is asserted only in IDLE, only to the winner.
  - Requesters must hold a/b/aluc stable while valid && !ready. The block samples operands only on the accept cycle, so later changes have no effect.
  - Result is held indefinitely in RESP until ready. No new request is accepted meanwhile; the other port stalls.
  - rspN_ready while rspN_valid=0 is ignored.
- ALU function codes are passed through unchanged:
  - x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 b<<16.
  - 0011 sll, 0111 srl, 1111 sra (shift by a).
  - Any other code yields 0; this is not an error.
- Widths: add/sub wrap mod 2^32, no overflow flag. The counter saturates at 2^CNT_W−1 and does not wrap.
- Reset (any state, including mid-EXEC/RESP):
  - Next edge: state=IDLE, all rsp*_valid=0, rsp*_r=0, rsp*_zero=0.
  - req*_ready=0 while reset is high; busy=0; cnt0=cnt1=0; last_grant=1.
  - An in-flight op is discarded and no response is issued.
- Outputs of the non-owner port: rsp_valid=0; rsp_r holds its last value (not cleared).

Test Plan:
- Port 0 only: a=0x00000005, b=0x00000003, aluc=0000, accepted T → rsp0_valid at T+2, r=0x00000008, zero=0; cnt0=1 after ready.
- Both ports valid every cycle from reset, immediate ready: grants alternate 0,1,0,1. Port 1 sub a=7,b=7 → r=0, zero=1. Repeat with P0_PRIORITY=1 → only port 0 ever served.
- Shifts via port 1:
  - aluc=1111, a=4, b=0x80000000 → 0xF8000000.
  - aluc=0111 same operands → 0x08000000.
  - aluc=0110 (lui), b=0x0000ABCD → 0xABCD0000.
- Backpressure: hold rsp0_ready=0 for 5 cycles while req1_valid=1 → rsp0_r stable, req1_ready stays 0. Release → port 1 granted in the next IDLE cycle.
- Reset asserted during RESP with rsp1_valid=1 → next edge rsp1_valid=0, busy=0, counters 0. First post-reset tie grants port 0.
- CNT_W=2: five port-0 ops → cnt0 reads 3 after the third op and stays 3.
